pipelined_borrow_subtractor: RTL

- Subtraction counterpart to the team's generate-built ripple-carry adder.
- Computes diff = a - b - bi and a borrow-out bo, for SIZE-bit operands.
- The borrow chain is split into CHUNK-bit slices, one slice per pipeline stage, built with a generate loop over stages.
- Valid/ready handshakes on both sides; sits in datapaths that consume adder results and need a registered subtract at high clock rate.

---
 rtl/pipelined_borrow_subtractor.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pipelined_borrow_subtractor.sv
// pipelined_borrow_subtractor
//   Registered subtractor: diff = a - b - bi (mod 2^SIZE), bo = borrow-out.
//   The borrow chain is cut into CHUNK-bit slices. Each slice is resolved in
//   its own pipeline stage, so the latency is STAGES = SIZE/CHUNK cycles.
//   Stage registers stall as a unit whenever the output is held.
//
// Ports
//   clk        clock; all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   upstream offers a, b, bi
//   in_ready   operand set is accepted this cycle (combinational)
//   a, b, bi   minuend, subtrahend, borrow-in
//   out_valid  diff/bo hold a valid result
//   out_ready  downstream accepts the result
//   diff, bo   difference and borrow-out (registered)
//
// SIZE must be a multiple of CHUNK. SIZE == CHUNK gives a single stage.

module pipelined_borrow_subtractor #(
    parameter int unsigned SIZE  = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            bi,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] diff,
    output logic            bo
);

    localparam int unsigned STAGES = SIZE / CHUNK;

    // Ripple-borrow across one CHUNK-bit slice; returns {borrow_out, diff_slice}.
    function automatic logic [CHUNK:0] slice_sub(
        input logic [CHUNK-1:0] x,
        input logic [CHUNK-1:0] y,
        input logic             br_in
    );
        logic [CHUNK-1:0] d;
        logic             br;
        d  = '0;
        br = br_in;
        for (int i = 0; i < CHUNK; i++) begin
            d[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        return {br, d};
    endfunction

    // Pipeline state. a_q/b_q hold the operands shifted right so that the
    // next stage always finds its slice in the low CHUNK bits (operand skew).
    // diff_q accumulates the slices already resolved.
    logic [SIZE-1:0]            a_q    [STAGES];
    logic [SIZE-1:0]            b_q    [STAGES];
    logic [SIZE-1:0]            diff_q [STAGES];
    logic [STAGES-1:0]          br_q;
    logic [STAGES-1:0]          vld_q;

    // Combinational slice results, one per stage.
    logic [STAGES-1:0][CHUNK:0] slice_c;

    // Whole pipeline moves together unless a finished result is being held.
    logic adv;
    assign adv      = !vld_q[STAGES-1] || out_ready;
    assign in_ready = adv;

    // Per-stage borrow slice: stage 0 works on the live inputs, later stages
    // on the skewed operands and registered borrow of the stage before.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        logic [CHUNK-1:0] x;
        logic [CHUNK-1:0] y;
        logic             br_in;

        if (s == 0) begin : g_first
            assign x     = a[CHUNK-1:0];
            assign y     = b[CHUNK-1:0];
            assign br_in = bi;
        end else begin : g_next
            assign x     = a_q[s-1][CHUNK-1:0];
            assign y     = b_q[s-1][CHUNK-1:0];
            assign br_in = br_q[s-1];
        end

        assign slice_c[s] = slice_sub(x, y, br_in);
    end

    // Stage registers; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            br_q  <= '0;
            for (int s = 0; s < STAGES; s++) begin
                a_q[s]    <= '0;
                b_q[s]    <= '0;
                diff_q[s] <= '0;
            end
        end else if (adv) begin
            vld_q[0]  <= in_valid;
            br_q[0]   <= slice_c[0][CHUNK];
            diff_q[0] <= SIZE'(slice_c[0][CHUNK-1:0]);
            a_q[0]    <= a >> CHUNK;
            b_q[0]    <= b >> CHUNK;
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s]  <= vld_q[s-1];
                br_q[s]   <= slice_c[s][CHUNK];
                diff_q[s] <= diff_q[s-1]
                           | (SIZE'(slice_c[s][CHUNK-1:0]) << (s * CHUNK));
                a_q[s]    <= a_q[s-1] >> CHUNK;
                b_q[s]    <= b_q[s-1] >> CHUNK;
            end
        end
    end

    // Final stage drives the outputs directly.
    assign out_valid = vld_q[STAGES-1];
    assign diff      = diff_q[STAGES-1];
    assign bo        = br_q[STAGES-1];

endmodule
